// File: rtl/rf_writeback_arb.sv
// Register-file writeback arbiter: merges load and ALU results into one
// in-order queue and issues at most one register write per cycle.
// Optional build macro: WB_FWD_EN enables the queued-data forwarding query.
module rf_writeback_arb #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    input  logic [3:0]  ld_reg,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic        alu_valid,
    input  logic [3:0]  alu_reg,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    output logic        write,
    output logic [3:0]  write_reg,
    output logic [31:0] write_data,
    output logic [15:0] busy_mask,
    input  logic [3:0]  qry_reg,
    output logic        qry_hit,
    output logic [31:0] qry_data
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    reg_q  [DEPTH];
    logic [3:0]    reg_d  [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];

    logic          ld_acc;
    logic          alu_acc;
    logic          pop;
    logic [PW-1:0] alu_idx;

    // Readies look only at the registered occupancy; a same-cycle pop is not credited.
    always_comb begin
        ld_ready  = count_q < CW'(DEPTH);
        alu_ready = (count_q < CW'(DEPTH - 1)) ||
                    ((count_q == CW'(DEPTH - 1)) && !ld_valid);
    end

    // Enqueue (load older than ALU), head pop and pointer/count update.
    always_comb begin
        ld_acc   = ld_valid && ld_ready;
        alu_acc  = alu_valid && alu_ready;
        pop      = count_q != CW'(0);
        reg_d    = reg_q;
        data_d   = data_q;
        alu_idx  = ld_acc ? PW'(wr_ptr_q + PW'(1)) : wr_ptr_q;
        if (ld_acc) begin
            reg_d[wr_ptr_q]  = ld_reg;
            data_d[wr_ptr_q] = ld_data;
        end
        if (alu_acc) begin
            reg_d[alu_idx]  = alu_reg;
            data_d[alu_idx] = alu_data;
        end
        wr_ptr_d = PW'(wr_ptr_q + PW'(ld_acc) + PW'(alu_acc));
        rd_ptr_d = PW'(rd_ptr_q + PW'(pop));
        count_d  = CW'(count_q + CW'(ld_acc) + CW'(alu_acc) - CW'(pop));
    end

    // Queue control state; reset discards every queued entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful inside the valid window.
    always_ff @(posedge clk) begin
        reg_q  <= reg_d;
        data_q <= data_d;
    end

    // Head issue; the strobe is held off during reset so discarded entries never commit.
    always_comb begin
        write      = (count_q != CW'(0)) && !rst;
        write_reg  = 4'h0;
        write_data = 32'h0;
        if (write) begin
            write_reg  = reg_q[rd_ptr_q];
            write_data = data_q[rd_ptr_q];
        end
    end

    // Pending-write mask over the valid window of the queue.
    always_comb begin
        busy_mask = 16'h0000;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (CW'(i) < count_q) begin
                busy_mask[reg_q[PW'(rd_ptr_q + PW'(i))]] = 1'b1;
            end
        end
    end

`ifdef WB_FWD_EN
    // Forwarding search from oldest to youngest so the youngest match wins.
    always_comb begin
        qry_hit  = 1'b0;
        qry_data = 32'h0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if ((CW'(i) < count_q) && (reg_q[PW'(rd_ptr_q + PW'(i))] == qry_reg)) begin
                qry_hit  = 1'b1;
                qry_data = data_q[PW'(rd_ptr_q + PW'(i))];
            end
        end
    end
`else
    logic unused_qry;

    // Forwarding disabled: query outputs tied off.
    always_comb begin
        unused_qry = ^qry_reg;
        qry_hit    = 1'b0;
        qry_data   = 32'h0;
    end
`endif

endmodule

// File: tb/tb_rf_writeback_arb.sv
// Scoreboard bench for rf_writeback_arb: the driver pushes accepted results,
// an independent monitor pops and compares every issued register write.
module tb_rf_writeback_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_valid = 1'b0;
    logic [3:0]  ld_reg = 4'h0;
    logic [31:0] ld_data = 32'h0;
    logic        ld_ready;
    logic        alu_valid = 1'b0;
    logic [3:0]  alu_reg = 4'h0;
    logic [31:0] alu_data = 32'h0;
    logic        alu_ready;
    logic        write;
    logic [3:0]  write_reg;
    logic [31:0] write_data;
    logic [15:0] busy_mask;
    logic [3:0]  qry_reg = 4'h0;
    logic        qry_hit;
    logic [31:0] qry_data;

    int checks = 0;
    int failures = 0;
    logic [35:0] sb[$];

    rf_writeback_arb #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_reg(ld_reg), .ld_data(ld_data), .ld_ready(ld_ready),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .write(write), .write_reg(write_reg), .write_data(write_data),
        .busy_mask(busy_mask),
        .qry_reg(qry_reg), .qry_hit(qry_hit), .qry_data(qry_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; accepted results go to the scoreboard in age order.
    task automatic drive(input logic lv, input logic [3:0] lr, input logic [31:0] lw,
                         input logic av, input logic [3:0] ar, input logic [31:0] aw,
                         output logic la, output logic aa);
        @(negedge clk);
        ld_valid  = lv;
        ld_reg    = lr;
        ld_data   = lw;
        alu_valid = av;
        alu_reg   = ar;
        alu_data  = aw;
        #1;
        la = lv && ld_ready;
        aa = av && alu_ready;
        if (la) sb.push_back({lr, lw});
        if (aa) sb.push_back({ar, aw});
    endtask

    task automatic idle();
        logic a, b;
        drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, a, b);
    endtask

    // Monitor: every write must match the oldest outstanding accepted result.
    initial begin
        logic [35:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                check("write_during_reset", 32'(write), 32'h0);
            end else if (write) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", 32'(write), 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("write_reg", 32'(write_reg), 32'(e[35:32]));
                    check("write_data", write_data, e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic la, aa;
        logic [3:0]  lt_reg, at_reg;
        logic [31:0] lt_data, at_data;
        int n;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_write", 32'(write), 32'h0);
        check("rst_busy", 32'(busy_mask), 32'h0);
        check("rst_ld_ready", 32'(ld_ready), 32'h1);
        check("rst_alu_ready", 32'(alu_ready), 32'h1);

        // Single ALU result: one-cycle latency and busy bit lifetime
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'd3, 32'hDEADBEEF, la, aa);
        check("t2_alu_acc", 32'(aa), 32'h1);
        idle();
        check("t2_write", 32'(write), 32'h1);
        check("t2_busy", 32'(busy_mask), 32'h0008);
        idle();
        check("t2_write_done", 32'(write), 32'h0);
        check("t2_busy_clear", 32'(busy_mask), 32'h0);

        // Same-cycle load and ALU to one register: load first
        drive(1'b1, 4'd2, 32'h11, 1'b1, 4'd2, 32'h22, la, aa);
        check("t3_acc", 32'({la, aa}), 32'h3);
        idle();
        check("t3_n1_busy", 32'(busy_mask), 32'h0004);
        idle();
        check("t3_n2_write", 32'(write), 32'h1);
        idle();
        check("t3_n3_write", 32'(write), 32'h0);

        // Both sources streaming: ALU stalls once three entries are queued
        lt_reg = 4'd0; lt_data = 32'h1000;
        at_reg = 4'd8; at_data = 32'h2000;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, lt_reg, lt_data, 1'b1, at_reg, at_data, la, aa);
            check("t4_ld_ready", 32'(la), 32'h1);
            check("t4_alu_ready", 32'(aa), (i < 2) ? 32'h1 : 32'h0);
            if (la) begin lt_reg = 4'(lt_reg + 4'd1); lt_data = lt_data + 32'h1; end
            if (aa) begin at_reg = 4'(at_reg + 4'd1); at_data = at_data + 32'h1; n++; end
        end
        drive(1'b0, 4'h0, 32'h0, 1'b1, at_reg, at_data, la, aa);
        check("t4_alu_after_ld_idle", 32'(aa), 32'h1);
        repeat (5) idle();
        check("t4_drained", 32'(sb.size()), 32'h0);
        check("t4_write_idle", 32'(write), 32'h0);

        // r15 order preserved like any other register
        drive(1'b1, 4'd15, 32'h0F0F0001, 1'b1, 4'd15, 32'h0F0F0002, la, aa);
        check("r15_acc", 32'({la, aa}), 32'h3);
        idle();
        check("r15_busy", 32'(busy_mask), 32'h8000);
        repeat (2) idle();

        // Reset with three entries queued: none of them may be written
        drive(1'b1, 4'd1, 32'hA1, 1'b1, 4'd2, 32'hA2, la, aa);
        drive(1'b1, 4'd3, 32'hA3, 1'b1, 4'd4, 32'hA4, la, aa);
        @(negedge clk);
        ld_valid = 1'b0;
        alu_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("t5_busy_before", 32'(busy_mask), 32'h001C);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_write_after", 32'(write), 32'h0);
        check("t5_busy_after", 32'(busy_mask), 32'h0);
        repeat (3) idle();

        // Forwarding query
        qry_reg = 4'd5;
        drive(1'b1, 4'd5, 32'hA, 1'b1, 4'd5, 32'hB, la, aa);
        idle();
`ifdef WB_FWD_EN
        check("t6_hit", 32'(qry_hit), 32'h1);
        check("t6_data", qry_data, 32'hB);
        qry_reg = 4'd6;
        #1;
        check("t6_miss_hit", 32'(qry_hit), 32'h0);
        check("t6_miss_data", qry_data, 32'h0);
`else
        check("t6_hit_off", 32'(qry_hit), 32'h0);
        check("t6_data_off", qry_data, 32'h0);
`endif

        // Bounded drain of anything still outstanding
        for (int i = 0; i < 50 && sb.size() != 0; i++) idle();
        check("final_drained", 32'(sb.size()), 32'h0);
        repeat (2) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
